// File: rtl/wb_arbiter_if.sv
// Write-back bus between the result producers and the arbiter.
// It carries the ALU and slow-path handshakes and the register-file write port.
interface wb_arbiter_if #(
  parameter int DW = 32
);
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    input  alu_ready,
    output mem_valid, mem_waddr, mem_wdata,
    input  mem_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    output alu_ready,
    input  mem_valid, mem_waddr, mem_wdata,
    output mem_ready,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU path and a FIFO-buffered slow path onto one
// register-file write port. Define WB_FWD_EN to add the operand-forwarding lookup.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  wb_arbiter_if.slave              wb,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]               fwd_raddr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          rf_we_reg, rf_we_next;
  logic [4:0]    rf_waddr_reg, rf_waddr_next;
  logic [DW-1:0] rf_wdata_reg, rf_wdata_next;

  logic [4:0]    addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic full, empty, alu_wr, push, pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Both ready signals look only at the registered count, never at a same-cycle pop.
  assign wb.alu_ready = !full;
  assign wb.mem_ready = !full;

  assign alu_wr = wb.alu_valid && !full && (wb.alu_waddr != 5'd0);
  assign push   = wb.mem_valid && !full && !flush && (wb.mem_waddr != 5'd0);
  // A full FIFO always drains, which bounds how long ALU traffic can starve it.
  assign pop    = full || (!alu_wr && !empty && !flush);

  always_comb begin
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    if (pop) begin
      rf_we_next    = 1'b1;
      rf_waddr_next = addr_mem[rd_ptr_reg];
      rf_wdata_next = data_mem[rd_ptr_reg];
    end else if (alu_wr) begin
      rf_we_next    = 1'b1;
      rf_waddr_next = wb.alu_waddr;
      rf_wdata_next = wb.alu_wdata;
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(pop);
    wr_ptr_next = wr_ptr_reg + PW'(push);
    count_next  = count_reg + CW'(push) - CW'(pop);
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= wb.mem_waddr;
      data_mem[wr_ptr_reg] <= wb.mem_wdata;
    end
  end

  assign wb.rf_we    = rf_we_reg;
  assign wb.rf_waddr = rf_waddr_reg;
  assign wb.rf_wdata = rf_wdata_reg;
  assign count       = count_reg;
  assign busy        = (count_reg != '0) || rf_we_reg;

`ifdef WB_FWD_EN
  // Entries are indexed by age: 0 is the FIFO head (oldest).
  logic [DEPTH-1:0] ent_hit;
  logic [DW-1:0]    ent_data [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PW-1:0] slot;
    assign slot         = rd_ptr_reg + PW'(gi);
    assign ent_hit[gi]  = (CW'(gi) < count_reg) && (addr_mem[slot] == fwd_raddr);
    assign ent_data[gi] = data_mem[slot];
  end

  // Later matches override earlier ones so the youngest write wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_raddr != 5'd0) begin
      if (rf_we_reg && (rf_waddr_reg == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wdata_reg;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_hit[i]) begin
          fwd_hit  = 1'b1;
          fwd_data = ent_data[i];
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised scoreboard bench for wb_arbiter: a queue-based model predicts every
// register-file write and its cycle; a monitor pops and compares observed writes.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
`ifdef WB_FWD_EN
  logic [4:0]             fwd_raddr;
  logic                   fwd_hit;
  logic [DW-1:0]          fwd_data;
`endif

  always #5 clk = ~clk;

  wb_arbiter_if #(.DW(DW)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wb    (bus),
    .flush (flush),
    .count (count),
    .busy  (busy)
`ifdef WB_FWD_EN
    ,
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  wr_t  mq[$];      // model of the slow-path queue contents
  exp_t expq[$];    // predicted register-file writes
  bit   cur_we;     // model of rf_we as currently shown
  wr_t  cur;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t e_mon;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every observed write must be the next predicted one, in the predicted cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.rf_we === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL extra_write: got x%0d=%h at cycle %0d want no write",
                   bus.rf_waddr, bus.rf_wdata, cyc);
        end else begin
          e_mon = expq.pop_front();
          if (bus.rf_waddr !== e_mon.addr || bus.rf_wdata !== e_mon.data || cyc != e_mon.cyc) begin
            errors++;
            $display("FAIL rf_write: got x%0d=%h at cycle %0d want x%0d=%h at cycle %0d",
                     bus.rf_waddr, bus.rf_wdata, cyc, e_mon.addr, e_mon.data, e_mon.cyc);
          end else begin
            $display("write cycle=%0d x%0d <= %h", cyc, bus.rf_waddr, bus.rf_wdata);
          end
        end
      end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: got rf_we=0 at cycle %0d want x%0d=%h",
                 cyc, expq[0].addr, expq[0].data);
        void'(expq.pop_front());
      end
    end
  end

  // One cycle: check visible state against the model, drive inputs, predict the next write.
  task automatic step(input bit av, input logic [4:0] aa, input logic [DW-1:0] ad,
                      input bit mv, input logic [4:0] ma, input logic [DW-1:0] md,
                      input bit fl);
    bit  full, nxt_we;
    wr_t w;
    full = (mq.size() == DEPTH);
    check("count", 64'(count), 64'(mq.size()));
    check("alu_ready", 64'(bus.alu_ready), 64'(!full));
    check("mem_ready", 64'(bus.mem_ready), 64'(!full));
    check("busy", 64'(busy), 64'((mq.size() != 0) || cur_we));

    bus.alu_valid = av;
    bus.alu_waddr = aa;
    bus.alu_wdata = ad;
    bus.mem_valid = mv;
    bus.mem_waddr = ma;
    bus.mem_wdata = md;
    flush         = fl;

`ifdef WB_FWD_EN
    begin
      bit            fhit;
      logic [DW-1:0] fdat;
      fwd_raddr = 5'($urandom_range(0, 7));
      #1;
      fhit = 1'b0;
      fdat = '0;
      if (fwd_raddr != 5'd0) begin
        if (cur_we && cur.addr == fwd_raddr) begin
          fhit = 1'b1;
          fdat = cur.data;
        end
        foreach (mq[i]) begin
          if (mq[i].addr == fwd_raddr) begin
            fhit = 1'b1;
            fdat = mq[i].data;
          end
        end
      end
      check("fwd_hit", 64'(fwd_hit), 64'(fhit));
      check("fwd_data", 64'(fwd_data), 64'(fdat));
    end
`endif

    nxt_we = 1'b0;
    w      = '{5'd0, '0};
    if (full) begin
      w      = mq.pop_front();
      nxt_we = 1'b1;
    end else if (av && aa != 5'd0) begin
      w      = '{aa, ad};
      nxt_we = 1'b1;
    end else if (mq.size() != 0 && !fl) begin
      w      = mq.pop_front();
      nxt_we = 1'b1;
    end
    if (fl) mq.delete();
    else if (mv && !full && ma != 5'd0) mq.push_back('{ma, md});
    if (nxt_we) expq.push_back('{w.addr, w.data, cyc + 1});
    cur_we = nxt_we;
    if (nxt_we) cur = w;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, '0, 0, 5'd0, '0, 0);
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_waddr = '0;
    bus.alu_wdata = '0;
    bus.mem_valid = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    flush         = 1'b0;
    #1;
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    mq.delete();
    expq.delete();
    cur_we = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    flush = 1'b0;
`ifdef WB_FWD_EN
    fwd_raddr = '0;
`endif
    #2;
    do_reset();

    // Single ALU write.
    step(1, 5'd5, 32'h1234, 0, 5'd0, '0, 0);
    idle(2);

    // Slow-path writes 1..4 with the ALU idle.
    for (int i = 1; i <= 4; i++) step(0, 5'd0, '0, 1, 5'(i), 32'h100 + i, 0);
    idle(4);

    // ALU held busy while four slow results fill the FIFO.
    for (int i = 0; i < 7; i++)
      step(1, 5'(7 + i), 32'h700 + i, i < 4, 5'(1 + i), 32'h200 + i, 0);
    idle(6);

    // Handshakes to x0 on both ports.
    for (int i = 0; i < 3; i++) step(1, 5'd0, 32'hdead, 1, 5'd0, 32'hbeef, 0);
    idle(2);

    // Queue three entries behind ALU traffic, then flush.
    for (int i = 0; i < 3; i++) step(1, 5'(10 + i), 32'h300 + i, 1, 5'(20 + i), 32'h400 + i, 0);
    step(0, 5'd0, '0, 1, 5'd25, 32'h555, 1);
    idle(3);

    // Random traffic with occasional flushes and one mid-run reset.
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) do_reset();
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 5, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 15) == 0);
    end
    idle(8);

    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
